if_id_skid_stage: RTL and testbench
===================================

// Module: if_id_skid_stage
// PURPOSE
// Parametrised IF/ID pipeline stage for the SQED-instrumented RISC-V core.
// Carries PC, instruction and per-entry QED-valid tag from fetch to decode
// over a valid/ready handshake, with a 2-entry skid buffer for full throughput
// under back-pressure. Adds flush-to-NOP and a saturating stall counter.
// PARAMETERS
// PC_W      32             PC width
// INSTR_W   32             instruction width
// QED_W     1              QED tag width, carried alongside each entry
// NOP_INSTR 32'h0000_0013  instruction driven when out_valid=0 (addi x0,x0,0)
// CNT_W     16             stall counter width
// PORTS
// clk            in   1        clock, all state on rising edge
// reset          in   1        asynchronous active-high reset, whole block
// outside_reset  in   1        synchronous clear of QED tags only
// flush          in   1        synchronous discard of all held entries
// in_valid       in   1        fetch presents an entry
// in_ready       out  1        stage can accept; registered (skid not full)
// in_pc          in   PC_W     fetch PC
// in_instr       in   INSTR_W  fetched instruction
// in_qed_vld     in   QED_W    QED-valid tag from fetch
// out_valid      out  1        decode-side entry valid
// out_ready      in   1        decode accepts this cycle
// out_pc         out  PC_W     head PC
// out_instr      out  INSTR_W  head instruction; NOP_INSTR when !out_valid
// out_qed_vld    out  QED_W    head QED tag; 0 when !out_valid
// stall_cnt      out  CNT_W    cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
// - Reset (async): both entries invalid, out_pc=0, out_instr=NOP_INSTR,
//   out_qed_vld=0, in_ready=1, stall_cnt=0. Outputs are registers, no comb path in->out.
// - Accept = in_valid & in_ready; drain = out_valid & out_ready.
// - States: EMPTY (main invalid) / ONE (main valid) / FULL (main+skid valid).
//   EMPTY: accept -> ONE (entry to main); else stay.
//   ONE: accept&drain -> ONE (new entry to main); accept&!drain -> FULL
//     (new entry to skid); !accept&drain -> EMPTY; else hold.
//   FULL: in_ready=0; drain -> ONE (skid moves to main); else hold.
// - Latency: in->out 1 cycle from EMPTY; throughput 1 entry/cycle in ONE.
// - Order strictly FIFO; no entry dropped or duplicated except by flush.
// - in_ready = !FULL, registered; in FULL it rises the cycle after drain.
// - flush: next state EMPTY regardless of accept/drain in the same cycle;
//   incoming entry discarded; out_pc=0, out_instr=NOP_INSTR, out_qed_vld=0.
// - outside_reset: zeroes QED tag of main and skid entries (and of an entry
//   accepted that cycle); PC/instr/valid unaffected. flush+outside_reset legal.
// - Invalid head: out_instr=NOP_INSTR and out_qed_vld=0 forced; out_pc holds last.
// - stall_cnt: +1 each cycle out_valid & !out_ready; holds at 2^CNT_W-1;
//   cleared only by reset (not flush).
// - reset mid-transfer: all entries lost, stall_cnt=0, no partial state.
// - in_valid while !in_ready: entry ignored; source must hold it.
// TESTING
// - Single entry: in pc=0x100 instr=0x00500093 qed=1, out_ready=1 -> next cycle
//   out_valid=1 with same values; following cycle out_valid=0, out_instr=0x13.
// - Back-pressure: stream pc 0x0,0x4,0x8 with out_ready=0 -> state FULL,
//   in_ready=0 after 2 accepts; release -> 0x0,0x4,0x8 out in order, no loss.
// - Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//   out_instr=0x13; flushed and incoming entries never appear at output.
// - outside_reset in FULL with qed=1 on both -> both drain with out_qed_vld=0,
//   PC/instr intact.
// - Stall counter, CNT_W=4: hold out_valid=1,out_ready=0 for 20 cycles ->
//   stall_cnt=15; flush -> still 15; reset -> 0.
// - Async reset asserted mid-cycle in ONE -> outputs at reset values
//   immediately, before next clk edge.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: carries PC, instruction and QED tag from fetch to decode
// through a two-entry skid buffer, with flush-to-NOP and a saturating stall counter.
//
// state   | meaning
// --------+-------------------------------------------------
// S_EMPTY | no valid entry; head shows NOP_INSTR, qed 0
// S_ONE   | main entry valid and presented to decode
// S_FULL  | main and skid valid; in_ready low
module if_id_skid_stage #(
   parameter int                 PC_W      = 32,
   parameter int                 INSTR_W   = 32,
   parameter int                 QED_W     = 1,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013),
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               outside_reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [QED_W-1:0]   in_qed_vld,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [QED_W-1:0]   out_qed_vld,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [PC_W-1:0]    skid_pc;
   logic [INSTR_W-1:0] skid_instr;
   logic [QED_W-1:0]   skid_qed;

   logic accept, drain;
   logic load_main_in, load_main_skid, load_skid_in;
   logic [QED_W-1:0] qed_keep;

   assign out_valid = (state_q != S_EMPTY);
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;
   assign qed_keep  = {QED_W{~outside_reset}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (accept) begin
               state_d      = S_ONE;
               load_main_in = 1'b1;
            end
         end
         S_ONE: begin
            if (accept && drain) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_d      = S_FULL;
               load_skid_in = 1'b1;
            end else if (drain) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (drain) begin
               state_d        = S_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      // flush overrides any accept/drain in the same cycle
      if (flush) begin
         state_d        = S_EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid_in   = 1'b0;
      end
   end

   // Main entry lives directly in the output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_pc      <= '0;
         out_instr   <= NOP_INSTR;
         out_qed_vld <= '0;
      end else if (flush) begin
         out_pc      <= '0;
         out_instr   <= NOP_INSTR;
         out_qed_vld <= '0;
      end else if (load_main_in) begin
         out_pc      <= in_pc;
         out_instr   <= in_instr;
         out_qed_vld <= in_qed_vld & qed_keep;
      end else if (load_main_skid) begin
         out_pc      <= skid_pc;
         out_instr   <= skid_instr;
         out_qed_vld <= skid_qed & qed_keep;
      end else if (state_d == S_EMPTY) begin
         out_instr   <= NOP_INSTR;
         out_qed_vld <= '0;
      end else if (outside_reset) begin
         out_qed_vld <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_pc    <= '0;
         skid_instr <= NOP_INSTR;
         skid_qed   <= '0;
      end else if (load_skid_in) begin
         skid_pc    <= in_pc;
         skid_instr <= in_instr;
         skid_qed   <= in_qed_vld & qed_keep;
      end else if (outside_reset) begin
         skid_qed <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) in_ready <= 1'b1;
      else       in_ready <= (state_d != S_FULL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: each scenario task drives vectors and
// compares outputs against hand-computed values.
module tb_if_id_skid_stage;

   localparam int PC_W = 32;
   localparam int INSTR_W = 32;
   localparam int QED_W = 1;
   localparam int CNT_W = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               outside_reset = 1'b0;
   logic               flush = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [PC_W-1:0]    in_pc = '0;
   logic [INSTR_W-1:0] in_instr = '0;
   logic [QED_W-1:0]   in_qed_vld = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;
   logic [QED_W-1:0]   out_qed_vld;
   logic [CNT_W-1:0]   stall_cnt;

   int tests = 0;
   int fails = 0;

   if_id_skid_stage #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .QED_W(QED_W),
      .NOP_INSTR(NOP), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .outside_reset(outside_reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_instr(in_instr), .in_qed_vld(in_qed_vld), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_qed_vld(out_qed_vld), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; outside_reset = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
      tests++; if (out_instr !== NOP) begin fails++; $display("FAIL reset_out_instr got %h exp %h", out_instr, NOP); end
      tests++; if (out_qed_vld !== 1'b0) begin fails++; $display("FAIL reset_out_qed got %b exp 0", out_qed_vld); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h0050_0093; in_qed_vld = 1'b1;
      tick();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", out_valid); end
      tests++; if (out_pc !== 32'h100) begin fails++; $display("FAIL single_pc got %h exp 100", out_pc); end
      tests++; if (out_instr !== 32'h0050_0093) begin fails++; $display("FAIL single_instr got %h exp 00500093", out_instr); end
      tests++; if (out_qed_vld !== 1'b1) begin fails++; $display("FAIL single_qed got %b exp 1", out_qed_vld); end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drained_valid got %b exp 0", out_valid); end
      tests++; if (out_instr !== NOP) begin fails++; $display("FAIL single_drained_instr got %h exp %h", out_instr, NOP); end
      tests++; if (out_qed_vld !== 1'b0) begin fails++; $display("FAIL single_drained_qed got %b exp 0", out_qed_vld); end
      tests++; if (out_pc !== 32'h100) begin fails++; $display("FAIL single_pc_hold got %h exp 100", out_pc); end
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_qed_vld = 1'b0;
      in_pc = 32'h0; in_instr = 32'hA000_0000;
      tick();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_one got %b exp 1", in_ready); end
      in_pc = 32'h4; in_instr = 32'hA000_0004;
      tick();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_full got %b exp 0", in_ready); end
      in_pc = 32'h8; in_instr = 32'hA000_0008;
      tick();
      tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL bp_head0 got %h exp 0", out_pc); end
      tests++; if (stall_cnt !== 4'd2) begin fails++; $display("FAIL bp_stall got %0d exp 2", stall_cnt); end
      out_ready = 1'b1;
      tick();
      tests++; if (out_pc !== 32'h4 || out_instr !== 32'hA000_0004) begin fails++; $display("FAIL bp_head1 got %h/%h exp 4/a0000004", out_pc, out_instr); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_drain got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      tests++; if (out_pc !== 32'h8 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_head2 got %h v=%b exp 8 v=1", out_pc, out_valid); end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [4];
      pcs[0] = 32'h200; pcs[1] = 32'h204; pcs[2] = 32'h208; pcs[3] = 32'h20C;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_pc = pcs[i]; in_instr = 32'hB000_0000 | pcs[i];
         tick();
         tests++; if (out_valid !== 1'b1 || out_pc !== pcs[i] || in_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_%0d got v=%b pc=%h rdy=%b exp v=1 pc=%h rdy=1", i, out_valid, out_pc, in_ready, pcs[i]);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h20; in_instr = 32'hC000_0020;
      tick();
      in_pc = 32'h24; in_instr = 32'hC000_0024;
      tick();
      flush = 1'b1; in_pc = 32'h28; in_instr = 32'hC000_0028;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
      tests++; if (out_instr !== NOP || out_pc !== 32'h0 || out_qed_vld !== 1'b0) begin
         fails++; $display("FAIL flush_head got %h/%h/%b exp 0/%h/0", out_pc, out_instr, out_qed_vld, NOP);
      end
      out_ready = 1'b1;
      tick();
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_ghost got %b exp 0", out_valid); end
   endtask

   task automatic test_outside_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_qed_vld = 1'b1;
      in_pc = 32'h40; in_instr = 32'hD000_0040;
      tick();
      in_pc = 32'h44; in_instr = 32'hD000_0044;
      tick();
      in_valid = 1'b0; outside_reset = 1'b1;
      tick();
      outside_reset = 1'b0;
      tests++; if (out_qed_vld !== 1'b0 || out_pc !== 32'h40 || out_instr !== 32'hD000_0040 || out_valid !== 1'b1) begin
         fails++; $display("FAIL orst_main got v=%b %h/%h/%b exp v=1 40/d0000040/0", out_valid, out_pc, out_instr, out_qed_vld);
      end
      out_ready = 1'b1;
      tick();
      tests++; if (out_qed_vld !== 1'b0 || out_pc !== 32'h44 || out_instr !== 32'hD000_0044) begin
         fails++; $display("FAIL orst_skid got %h/%h/%b exp 44/d0000044/0", out_pc, out_instr, out_qed_vld);
      end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL orst_empty got %b exp 0", out_valid); end
      in_qed_vld = 1'b0;
   endtask

   task automatic test_stall_counter();
      do_reset();
      in_valid = 1'b1; in_pc = 32'h60; in_instr = 32'hE000_0060;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (20) tick();
      tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL stall_sat got %0d exp 15", stall_cnt); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tests++; if (stall_cnt !== 4'd15) begin fails++; $display("FAIL stall_after_flush got %0d exp 15", stall_cnt); end
      do_reset();
      tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL stall_after_reset got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h80; in_instr = 32'hF000_0080; in_qed_vld = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tests++; if (out_valid !== 1'b1 || stall_cnt !== 4'd1) begin fails++; $display("FAIL arst_pre got v=%b cnt=%0d exp v=1 cnt=1", out_valid, stall_cnt); end
      #2 reset = 1'b1;
      #1;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 4'd0) begin
         fails++; $display("FAIL arst_ctrl got v=%b rdy=%b cnt=%0d exp 0/1/0", out_valid, in_ready, stall_cnt);
      end
      tests++; if (out_pc !== 32'h0 || out_instr !== NOP || out_qed_vld !== 1'b0) begin
         fails++; $display("FAIL arst_data got %h/%h/%b exp 0/%h/0", out_pc, out_instr, out_qed_vld, NOP);
      end
      tick();
      reset = 1'b0; in_qed_vld = 1'b0;
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_after got %b exp 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_pressure();
      test_back_to_back();
      test_flush();
      test_outside_reset();
      test_stall_counter();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
